// File: rtl/instr_aligner.sv
// instr_aligner: splits FIFO fetch words into 16/32-bit instructions with PC, one per cycle.
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  logic [31:0] i_fifo_data,
    input  logic        i_fifo_empty,
    output logic        o_fifo_pop,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_compressed
);
    logic [31:0] pc;
    logic [15:0] hold;
    logic        hold_valid, skip_lo;
    logic        span, hold_c, word_full, accept;
    always_comb begin
        span        = hold_valid && hold[1:0] == 2'b11;
        hold_c      = hold_valid && !span;
        word_full   = i_fifo_data[1:0] == 2'b11;
        o_valid     = !i_flush && !skip_lo && (hold_c || !i_fifo_empty);
        o_compressed = o_valid && (hold_c || (!hold_valid && !word_full));
        o_instr     = !o_valid ? 32'h0 :
                      hold_c   ? {16'h0, hold} :
                      span     ? {i_fifo_data[15:0], hold} :
                      word_full ? i_fifo_data : {16'h0, i_fifo_data[15:0]};
        accept      = o_valid && i_ready;
        // A held RVC instruction is consumed without touching the FIFO.
        o_fifo_pop  = !i_flush && ((skip_lo && !i_fifo_empty) || (accept && !hold_c));
        o_pc        = pc;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pc         <= RESET_PC;
            hold       <= 16'h0;
            hold_valid <= 1'b0;
            skip_lo    <= 1'b0;
        end else if (i_flush) begin
            pc         <= i_flush_pc;
            hold_valid <= 1'b0;
            skip_lo    <= i_flush_pc[1];
        end else if (skip_lo) begin
            if (!i_fifo_empty) begin
                hold       <= i_fifo_data[31:16];
                hold_valid <= 1'b1;
                skip_lo    <= 1'b0;
            end
        end else if (accept) begin
            pc <= pc + (o_compressed ? 32'd2 : 32'd4);
            // Upper halfword stays pending after a straddle or a low RVC.
            if (!hold_c) hold <= i_fifo_data[31:16];
            hold_valid <= !hold_c && (span || !word_full);
        end
    end
endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: directed scenario tests for instr_aligner.
module tb_instr_aligner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop, valid, ready = 1'b0, compressed;
    logic [31:0] instr, pc;
    int errors = 0;
    int checks = 0;

    instr_aligner dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush), .i_flush_pc(flush_pc),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty), .o_fifo_pop(fifo_pop),
        .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc),
        .o_compressed(compressed)
    );

    always #5 clk = ~clk;

    // {valid, instr, pc, compressed, pop}
    logic [66:0] obs;
    assign obs = {valid, instr, pc, compressed, fifo_pop};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; fifo_empty = 1'b1; ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (obs !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, {1'b0, 32'h0, 32'h0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_word32();
        do_reset();
        fifo_data = 32'h00A00093; fifo_empty = 1'b0; ready = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL word32: got %h expected %h", obs, {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b1});
        end
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if ({valid, pc, fifo_pop} !== {1'b0, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL word32_next: got %h expected %h", {valid, pc, fifo_pop}, {1'b0, 32'h4, 1'b0});
        end
    endtask

    task automatic test_rvc_pair();
        do_reset();
        fifo_data = 32'h45014581; fifo_empty = 1'b0; ready = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h4581, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rvc_lo: got %h expected %h", obs, {1'b1, 32'h4581, 32'h0, 1'b1, 1'b1});
        end
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h4501, 32'h2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rvc_hi: got %h expected %h", obs, {1'b1, 32'h4501, 32'h2, 1'b1, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({valid, pc} !== {1'b0, 32'h4}) begin
            errors++;
            $display("FAIL rvc_done: got %h expected %h", {valid, pc}, {1'b0, 32'h4});
        end
    endtask

    task automatic test_straddle();
        do_reset();
        fifo_data = 32'h00934581; fifo_empty = 1'b0; ready = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h4581, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL straddle_c: got %h expected %h", obs, {1'b1, 32'h4581, 32'h0, 1'b1, 1'b1});
        end
        tick();
        fifo_data = 32'h450100A0;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h00A00093, 32'h2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL straddle_span: got %h expected %h", obs, {1'b1, 32'h00A00093, 32'h2, 1'b0, 1'b1});
        end
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h4501, 32'h6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL straddle_tail: got %h expected %h", obs, {1'b1, 32'h4501, 32'h6, 1'b1, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({valid, pc} !== {1'b0, 32'h8}) begin
            errors++;
            $display("FAIL straddle_end: got %h expected %h", {valid, pc}, {1'b0, 32'h8});
        end
    endtask

    task automatic test_span_delayed();
        do_reset();
        fifo_data = 32'h00934581; fifo_empty = 1'b0; ready = 1'b1;
        tick();
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({valid, pc, fifo_pop} !== {1'b0, 32'h2, 1'b0}) begin
                errors++;
                $display("FAIL span_wait%0d: got %h expected %h", i, {valid, pc, fifo_pop}, {1'b0, 32'h2, 1'b0});
            end
            tick();
        end
        fifo_data = 32'h450100A0; fifo_empty = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h00A00093, 32'h2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL span_resume: got %h expected %h", obs, {1'b1, 32'h00A00093, 32'h2, 1'b0, 1'b1});
        end
    endtask

    task automatic test_flush_skip();
        do_reset();
        fifo_data = 32'h00A00093; fifo_empty = 1'b0; ready = 1'b1;
        flush = 1'b1; flush_pc = 32'h102;
        #1;
        checks++;
        if ({valid, fifo_pop} !== 2'b00) begin
            errors++;
            $display("FAIL flush: got %b expected 00", {valid, fifo_pop});
        end
        tick();
        flush = 1'b0; fifo_data = 32'h12344581;
        #1;
        checks++;
        if ({valid, pc, fifo_pop} !== {1'b0, 32'h102, 1'b1}) begin
            errors++;
            $display("FAIL skip: got %h expected %h", {valid, pc, fifo_pop}, {1'b0, 32'h102, 1'b1});
        end
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h1234, 32'h102, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_skip: got %h expected %h", obs, {1'b1, 32'h1234, 32'h102, 1'b1, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({valid, pc} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL after_skip_pc: got %h expected %h", {valid, pc}, {1'b0, 32'h104});
        end
    endtask

    task automatic test_stall();
        do_reset();
        fifo_data = 32'h00A00093; fifo_empty = 1'b0; ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d: got %h expected %h", i, obs, {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b0});
            end
            tick();
        end
        ready = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", obs, {1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b1});
        end
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if ({valid, pc, fifo_pop} !== {1'b0, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL stall_once: got %h expected %h", {valid, pc, fifo_pop}, {1'b0, 32'h4, 1'b0});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFE; ready = 1'b1;
        tick();
        flush = 1'b0; fifo_data = 32'h00010000; fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 32'h0001, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_instr: got %h expected %h", obs, {1'b1, 32'h0001, 32'hFFFF_FFFE, 1'b1, 1'b0});
        end
        tick();
        #1;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %h expected 00000000", pc);
        end
    endtask

    task automatic test_flush_vs_reset();
        do_reset();
        fifo_data = 32'h00A00093; fifo_empty = 1'b0; ready = 1'b1;
        tick();
        reset_n = 1'b0; flush = 1'b1; flush_pc = 32'h200;
        tick();
        reset_n = 1'b1; flush = 1'b0; fifo_empty = 1'b1;
        #1;
        checks++;
        if ({valid, pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL flush_reset: got %h expected %h", {valid, pc}, {1'b0, 32'h0});
        end
    endtask

    initial begin
        test_reset();
        test_word32();
        test_rvc_pair();
        test_straddle();
        test_span_delayed();
        test_flush_skip();
        test_stall();
        test_wrap();
        test_flush_vs_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_aligner.md
# instr_aligner

- Instruction aligner between the instruction fetch FIFO and the decode stage.
- Consumes 32-bit, word-aligned fetch words from the FIFO head, which is first-word-fall-through and combinationally visible.
- Splits each word into 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two words.
- Presents one instruction per cycle with its PC under a valid/ready handshake, and handles redirects to halfword-aligned targets.

## Interface
- RESET_PC, default 32'h0000_0000: PC after reset. Bits [1:0] must be 0.
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  redirect (branch/jump/trap). Fetch and FIFO are flushed in the same cycle by their owners.
- i_flush_pc  in  32  redirect target. Bit 0 is 0; bit 1 may be 1.
- i_fifo_data  in  32  FIFO head word.
- i_fifo_empty  in  1  FIFO empty.
- o_fifo_pop  out  1  pop the FIFO head.
- o_valid  out  1  instruction available.
- i_ready  in  1  decode accepts the instruction.
- o_instr  out  32  instruction. Compressed instructions are zero-extended to 32 bits. Drives 0 when !o_valid.
- o_pc  out  32  PC of o_instr.
- o_compressed  out  1  o_instr is 16-bit (bits [1:0] != 2'b11).

## Operation
- State registers:
  - pc[31:0]
  - hold[15:0] and hold_valid: upper halfword of the last popped word, not yet consumed.
  - skip_lo: the next FIFO word's low halfword lies before the target PC and must be discarded.
- Modes, priority-ordered:
  - FLUSH (i_flush=1): o_valid=0, o_fifo_pop=0. Next edge: pc<=i_flush_pc, hold_valid<=0, skip_lo<=i_flush_pc[1].
  - SKIP (skip_lo=1): o_valid=0. If !i_fifo_empty: o_fifo_pop=1, hold<=i_fifo_data[31:16], hold_valid<=1, skip_lo<=0.
  - HOLD_C (hold_valid, hold[1:0]!=11): o_instr={16'h0,hold}, o_compressed=1, o_valid=1. Needs no FIFO word. On accept: hold_valid<=0, no pop.
  - HOLD_SPAN (hold_valid, hold[1:0]==11): o_valid=!i_fifo_empty, o_instr={i_fifo_data[15:0],hold}. On accept: pop, hold<=i_fifo_data[31:16], hold_valid stays 1.
  - WORD (!hold_valid): o_valid=!i_fifo_empty.
    - If i_fifo_data[1:0]==11: o_instr=i_fifo_data. On accept: pop, hold_valid stays 0.
    - Else: o_instr={16'h0,i_fifo_data[15:0]}, compressed. On accept: pop, hold<=i_fifo_data[31:16], hold_valid<=1.
- accept = o_valid & i_ready.
- On accept, pc <= pc + (o_compressed ? 2 : 4), modulo 2^32. o_pc=pc at all times.
- o_fifo_pop is asserted only on accept in WORD/HOLD_SPAN, or in SKIP. It is never asserted when i_fifo_empty=1 or i_flush=1.
- When !accept, all state holds. o_instr/o_pc/o_compressed stay stable while o_valid=1 and the FIFO head is unchanged.

## Timing
- Reset values: pc=RESET_PC, hold_valid=0, hold=0, skip_lo=0. Outputs: o_valid=0 (FIFO empty), o_fifo_pop=0, o_instr=0, o_pc=RESET_PC, o_compressed=0.
- Combinational path from FIFO head and i_ready to o_valid/o_instr/o_fifo_pop. Zero-cycle latency from head word to instruction.
- State updates occur on the rising edge of i_clk.
- Peak throughput is one instruction per cycle. A word holding two RVC instructions takes 2 cycles and pops once.
- A redirect to a PC with pc[1]=1 costs one SKIP bubble cycle after the first word arrives.
- i_flush together with accept: flush wins. No pop, pc=i_flush_pc.
- i_flush together with reset: reset wins.
- Empty FIFO in HOLD_SPAN: o_valid=0, state held. A half-instruction is never emitted.
- PC wrap 0xFFFF_FFFE + 2 gives 0x0000_0000.

## Test plan
- Reset, RESET_PC=0, head 0x00A00093, i_ready=1 -> o_valid=1, o_instr=0x00A00093, o_pc=0, o_compressed=0, o_fifo_pop=1. Next cycle o_pc=4.
- Head 0x45014581, i_ready=1 -> cycle 1: instr 0x00004581, pc 0, compressed, pop. Cycle 2: instr 0x00004501, pc 2, pop=0 (FIFO empty, still valid).
- Words 0x00934581 then 0x450100A0 -> pc 0: 0x4581 (pop). Pc 2: 0x00A00093 (pop, straddling). Pc 6: 0x4501 (no pop).
- Straddle with second word delayed 3 cycles -> o_valid=0 for 3 cycles, pc=2 held. Then 0x00A00093 is emitted.
- i_flush=1, i_flush_pc=0x102 while o_valid=1 -> no pop, o_valid=0. Then head 0x12344581 -> one SKIP cycle with pop, o_valid=0. Next: instr 0x00001234, pc 0x102, compressed.
- i_ready=0 for 4 cycles with valid head -> o_fifo_pop=0, outputs and pc stable. Release -> single accept and single pop.
